// File: rtl/display_pkg.sv
// Shared definitions for the result display stage: FSM encoding, digit count
// and active-low 7-segment codes ({g,f,e,d,c,b,a}).
package display_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    EXIBE    = 2'd2
  } estado_t;

  localparam int N_DIG = 5;
  localparam int W_BCD = 4 * N_DIG;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] BLANK = 7'h7F;

endpackage

// File: rtl/dec_7seg.sv
// BCD digit to active-low 7-segment pattern. Codes above 9 turn every
// segment off.
module dec_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup of the digit pattern.
  always_comb begin
    seg = BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = BLANK;
    endcase
  end

endmodule

// File: rtl/exibe_resultado.sv
// Display stage for the polynomial unit: captures Resultado on a rising
// valido, converts it to 5 BCD digits with a one-step-per-clock double
// dabble, and scans a multiplexed active-low 7-segment display.
module exibe_resultado
  import display_pkg::*;
#(
  parameter int DIV_VARRE   = 4,
  parameter bit APAGA_ZEROS = 1'b1
) (
  input  logic        ck,
  input  logic        rst,
  input  logic        valido,
  input  logic [15:0] resultado,
  output logic [6:0]  seg,
  output logic [4:0]  an,
  output logic        ocupado,
  output logic        carregado
);

  localparam int              PW      = (DIV_VARRE > 1) ? $clog2(DIV_VARRE) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(DIV_VARRE - 1);
  localparam logic [2:0]      DIG_MAX = 3'(N_DIG - 1);

  estado_t            estado_reg, estado_next;
  logic               valido_q_reg;
  logic [15:0]        sh_reg, sh_next;
  logic [W_BCD-1:0]   bcd_reg, bcd_next;
  logic [3:0]         it_reg, it_next;
  logic [W_BCD-1:0]   disp_reg, disp_next;
  logic               ocupado_reg, ocupado_next;
  logic               carregado_reg, carregado_next;

  logic [PW-1:0]      pre_reg;
  logic [2:0]         dig_reg;
  logic [6:0]         seg_reg;
  logic [4:0]         an_reg;

  logic               captura;
  logic [W_BCD-1:0]   bcd_adj;
  logic [W_BCD+15:0]  cadeia;
  logic [3:0]         nib [N_DIG];
  logic [N_DIG-1:0]   acima_zero;
  logic [3:0]         nib_sel;
  logic [6:0]         seg_cod;
  logic               apaga;

  assign captura = valido & ~valido_q_reg;

  // Per-nibble double-dabble correction and the "this digit and every more
  // significant one is zero" flags used for leading-zero blanking.
  generate
    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_nib
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
      assign nib[gi]        = disp_reg[4*gi +: 4];
      assign acima_zero[gi] = (disp_reg[W_BCD-1:4*gi] == '0);
    end
  endgenerate

  // Edge detector on valido.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) valido_q_reg <= 1'b0;
    else      valido_q_reg <= valido;
  end

  // FSM and conversion datapath state register.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      estado_reg    <= OCIOSO;
      sh_reg        <= '0;
      bcd_reg       <= '0;
      it_reg        <= '0;
      disp_reg      <= '0;
      ocupado_reg   <= 1'b0;
      carregado_reg <= 1'b0;
    end else begin
      estado_reg    <= estado_next;
      sh_reg        <= sh_next;
      bcd_reg       <= bcd_next;
      it_reg        <= it_next;
      disp_reg      <= disp_next;
      ocupado_reg   <= ocupado_next;
      carregado_reg <= carregado_next;
    end
  end

  // Next state: start on capture, run 16 shift steps, publish the BCD result
  // only after the last step so the display never shows partial values.
  always_comb begin
    estado_next    = estado_reg;
    sh_next        = sh_reg;
    bcd_next       = bcd_reg;
    it_next        = it_reg;
    disp_next      = disp_reg;
    ocupado_next   = ocupado_reg;
    carregado_next = carregado_reg;
    cadeia         = {bcd_adj, sh_reg} << 1;
    case (estado_reg)
      OCIOSO, EXIBE: begin
        if (estado_reg == EXIBE) carregado_next = 1'b1;
        if (captura) begin
          sh_next      = resultado;
          bcd_next     = '0;
          it_next      = '0;
          ocupado_next = 1'b1;
          estado_next  = CONVERTE;
        end
      end
      CONVERTE: begin
        bcd_next = cadeia[W_BCD+15:16];
        sh_next  = cadeia[15:0];
        it_next  = it_reg + 4'd1;
        if (it_reg == 4'd15) begin
          disp_next      = cadeia[W_BCD+15:16];
          ocupado_next   = 1'b0;
          carregado_next = 1'b1;
          estado_next    = EXIBE;
        end
      end
      default: estado_next = OCIOSO;
    endcase
  end

  assign nib_sel = nib[dig_reg];
  assign apaga   = APAGA_ZEROS && (dig_reg != 3'd0) && acima_zero[dig_reg];

  dec_7seg u_dec (
    .bcd (nib_sel),
    .seg (seg_cod)
  );

  // Scan prescaler, digit pointer and registered display outputs.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      pre_reg <= '0;
      dig_reg <= '0;
      seg_reg <= BLANK;
      an_reg  <= 5'h1F;
    end else begin
      if (pre_reg == PRE_MAX) begin
        pre_reg <= '0;
        dig_reg <= (dig_reg == DIG_MAX) ? 3'd0 : dig_reg + 3'd1;
      end else begin
        pre_reg <= pre_reg + PW'(1);
      end
      if (carregado_reg) begin
        an_reg  <= ~(5'b00001 << dig_reg);
        seg_reg <= apaga ? BLANK : seg_cod;
      end else begin
        an_reg  <= 5'h1F;
        seg_reg <= BLANK;
      end
    end
  end

  assign seg       = seg_reg;
  assign an        = an_reg;
  assign ocupado   = ocupado_reg;
  assign carregado = carregado_reg;

endmodule
